// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the filter configuration controller.
package filter_ctrl_pkg;
  localparam int NUM_KEYS    = 3;
  localparam int NUM_PRESETS = 4;
  localparam int LVL_W       = 8;

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_e;

  localparam logic [LVL_W-1:0] THRESH_PRESET [NUM_PRESETS] = '{8'd80, 8'd100, 8'd128, 8'd160};
  localparam logic [LVL_W-1:0] BRIGHT_PRESET [NUM_PRESETS] = '{8'd150, 8'd120, 8'd100, 8'd60};

  typedef struct packed {
    logic       thresh_en;
    logic       bright_en;
    logic [1:0] preset_idx;
  } cfg_t;
endpackage

// File: rtl/key_debounce.sv
// Synchronizer, debouncer and press (debounced 1->0) detector for one raw active-low key.
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw_n,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   key_s;

  assign key_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press    <= 1'b0;
    end else begin
      sync_q[0] <= key_raw_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      press <= 1'b0;
      if (key_s == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Nth consecutive differing cycle: accept; only the falling side is a press.
        stable_q <= key_s;
        cnt_q    <= '0;
        press    <= ~key_s;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/filter_config_ctrl.sv
// Key-driven filter configuration: presses edit a shadow config that is applied
// only on a vsync falling edge, so the pipeline never sees a mid-frame change.
module filter_config_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       key_n,
  input  logic             vsync,
  output logic             thresh_enable,
  output logic             bright_enable,
  output logic [LVL_W-1:0] thresh_level,
  output logic [LVL_W-1:0] bright_level,
  output logic             cfg_update,
  output logic             cfg_pending
);
  logic [NUM_KEYS-1:0] press;
  logic                vsync_q;
  logic                vs_fall;
  logic                any_press;
  state_e              state_q, state_d;
  cfg_t                sh_q, sh_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .key_raw_n(key_n[k]),
      .press    (press[k])
    );
  end

  assign vs_fall   = vsync_q & ~vsync;
  assign any_press = |press;

  always_comb begin
    sh_d            = sh_q;
    sh_d.thresh_en  = sh_q.thresh_en ^ press[0];
    sh_d.bright_en  = sh_q.bright_en ^ press[1];
    sh_d.preset_idx = sh_q.preset_idx + {1'b0, press[2]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_press) state_d = PENDING;
      PENDING: if (vs_fall)   state_d = APPLY;
      APPLY:   state_d = any_press ? PENDING : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are loaded on the edge entering APPLY, so during APPLY they hold the
  // shadow as it stood at the start of that cycle (coincident presses included).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q       <= 1'b1;
      sh_q          <= '0;
      thresh_enable <= 1'b0;
      bright_enable <= 1'b0;
      thresh_level  <= THRESH_PRESET[0];
      bright_level  <= BRIGHT_PRESET[0];
      cfg_update    <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      sh_q       <= sh_d;
      cfg_update <= (state_d == APPLY);
      if (state_d == APPLY) begin
        thresh_enable <= sh_d.thresh_en;
        bright_enable <= sh_d.bright_en;
        thresh_level  <= THRESH_PRESET[sh_d.preset_idx];
        bright_level  <= BRIGHT_PRESET[sh_d.preset_idx];
      end
    end
  end

  assign cfg_pending = (state_q == PENDING);
endmodule

// File: tb/tb_filter_config_ctrl.sv
// Bench for filter_config_ctrl: directed corner sequences, a vector table, and
// random key/vsync operations scored against a transaction-level config model.
module tb_filter_config_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] key_n;
  logic       vsync;
  logic       thresh_enable, bright_enable, cfg_update, cfg_pending;
  logic [7:0] thresh_level, bright_level;

  int checks = 0;
  int failures = 0;
  int upd_total = 0;

  filter_config_ctrl #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .vsync(vsync),
    .thresh_enable(thresh_enable), .bright_enable(bright_enable),
    .thresh_level(thresh_level), .bright_level(bright_level),
    .cfg_update(cfg_update), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (cfg_update === 1'b1) upd_total++;

  typedef struct {
    int op; int mask;
    int te; int be; int tl; int bl; int pend; int upd;
  } vec_t;

  // Op codes: 0 press, 1 frame edge, 2 short glitch, 4 press coincident with
  // vsync fall, 5 press landing on the cycle after vsync fall.
  int tp[4] = '{80, 100, 128, 160};
  int bp[4] = '{150, 120, 100, 60};
  int m_te, m_be, m_idx, m_pend, a_te, a_be, a_idx;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(2);
  endtask

  task automatic do_op(input int op, input int mask);
    case (op)
      0: begin key_n = ~mask[2:0]; tick(10); key_n = 3'b111; tick(10); end
      1: begin vsync = 1'b0; tick(4); vsync = 1'b1; tick(4); end
      2: begin key_n = ~mask[2:0]; tick(3); key_n = 3'b111; tick(10); end
      4: begin key_n = ~mask[2:0]; tick(6); vsync = 1'b0; tick(4);
               key_n = 3'b111; vsync = 1'b1; tick(10); end
      5: begin key_n = ~mask[2:0]; tick(5); vsync = 1'b0; tick(5);
               key_n = 3'b111; vsync = 1'b1; tick(10); end
      default: tick(1);
    endcase
  endtask

  task automatic chk_all(input string tag, input int te, input int be, input int tl,
                         input int bl, input int pend, input int upd, input int upd_got);
    chk({tag, ".thresh_enable"}, thresh_enable, te);
    chk({tag, ".bright_enable"}, bright_enable, be);
    chk({tag, ".thresh_level"},  thresh_level,  tl);
    chk({tag, ".bright_level"},  bright_level,  bl);
    chk({tag, ".cfg_pending"},   cfg_pending,   pend);
    chk({tag, ".updates"},       upd_got,       upd);
  endtask

  task automatic m_press(input int mask);
    if (mask[0]) m_te ^= 1;
    if (mask[1]) m_be ^= 1;
    if (mask[2]) m_idx = (m_idx + 1) % 4;
    m_pend = 1;
  endtask

  task automatic m_apply();
    a_te = m_te; a_be = m_be; a_idx = m_idx; m_pend = 0;
  endtask

  task automatic model_op(input int op, input int mask, output int upd);
    upd = 0;
    case (op)
      0: m_press(mask);
      1: if (m_pend != 0) begin m_apply(); upd = 1; end
      4: if (m_pend != 0) begin m_press(mask); m_apply(); upd = 1; end
         else m_press(mask);
      5: if (m_pend != 0) begin m_apply(); upd = 1; m_press(mask); end
         else m_press(mask);
      default: ;
    endcase
  endtask

  vec_t tbl[22];
  int u0, eu, op, mask;

  initial begin
    tbl[0]  = '{0, 1, 0, 0, 80, 150, 1, 0};
    tbl[1]  = '{1, 0, 1, 0, 80, 150, 0, 1};
    tbl[2]  = '{1, 0, 1, 0, 80, 150, 0, 0};
    tbl[3]  = '{0, 4, 1, 0, 80, 150, 1, 0};
    tbl[4]  = '{0, 2, 1, 0, 80, 150, 1, 0};
    tbl[5]  = '{1, 0, 1, 1, 100, 120, 0, 1};
    tbl[6]  = '{2, 1, 1, 1, 100, 120, 0, 0};
    tbl[7]  = '{0, 4, 1, 1, 100, 120, 1, 0};
    tbl[8]  = '{0, 4, 1, 1, 100, 120, 1, 0};
    tbl[9]  = '{1, 0, 1, 1, 160, 60, 0, 1};
    tbl[10] = '{0, 4, 1, 1, 160, 60, 1, 0};
    tbl[11] = '{0, 1, 1, 1, 160, 60, 1, 0};
    tbl[12] = '{1, 0, 0, 1, 80, 150, 0, 1};
    tbl[13] = '{0, 7, 0, 1, 80, 150, 1, 0};
    tbl[14] = '{1, 0, 1, 0, 100, 120, 0, 1};
    tbl[15] = '{0, 1, 1, 0, 100, 120, 1, 0};
    tbl[16] = '{4, 2, 0, 1, 100, 120, 0, 1};
    tbl[17] = '{5, 4, 0, 1, 100, 120, 1, 0};
    tbl[18] = '{5, 1, 0, 1, 128, 100, 1, 1};
    tbl[19] = '{1, 0, 1, 1, 128, 100, 0, 1};
    tbl[20] = '{4, 4, 1, 1, 128, 100, 1, 0};
    tbl[21] = '{1, 0, 1, 1, 160, 60, 0, 1};

    key_n = 3'b111; vsync = 1'b1; reset_n = 1'b0;
    tick(2); reset_n = 1'b1; tick(20);
    chk_all("idle", 0, 0, 80, 150, 0, 0, upd_total);

    // 3-cycle glitch is one short of the debounce window
    u0 = upd_total;
    key_n[0] = 1'b0; tick(3); key_n[0] = 1'b1; tick(10);
    chk("glitch.cfg_pending", cfg_pending, 0);
    chk("glitch.updates", upd_total - u0, 0);

    // Long hold mid-frame, then exact one-cycle apply latency
    key_n[0] = 1'b0; tick(20);
    chk("hold.cfg_pending", cfg_pending, 1);
    chk("hold.thresh_enable", thresh_enable, 0);
    key_n[0] = 1'b1; tick(10);
    vsync = 1'b0;
    chk("edge0.thresh_enable", thresh_enable, 0);
    chk("edge0.cfg_update", cfg_update, 0);
    tick(1);
    chk("edge1.thresh_enable", thresh_enable, 1);
    chk("edge1.cfg_update", cfg_update, 1);
    chk("edge1.cfg_pending", cfg_pending, 0);
    tick(1);
    chk("edge2.cfg_update", cfg_update, 0);
    tick(2); vsync = 1'b1; tick(4);

    // Four preset steps wrap back to preset 0
    for (int i = 0; i < 4; i++) do_op(0, 4);
    u0 = upd_total;
    do_op(1, 0);
    chk("wrap.thresh_level", thresh_level, 80);
    chk("wrap.bright_level", bright_level, 150);
    chk("wrap.updates", upd_total - u0, 1);

    // Brightness press landing on the APPLY cycle goes to the next frame
    do_op(0, 1);
    key_n[1] = 1'b0; tick(5); vsync = 1'b0; tick(1);
    chk("onapply.cfg_update", cfg_update, 1);
    chk("onapply.thresh_enable", thresh_enable, 0);
    chk("onapply.bright_enable", bright_enable, 0);
    tick(1);
    chk("onapply.cfg_pending", cfg_pending, 1);
    tick(3); vsync = 1'b1; key_n[1] = 1'b1; tick(10);
    do_op(1, 0);
    chk("nextframe.bright_enable", bright_enable, 1);
    chk("nextframe.thresh_enable", thresh_enable, 0);

    // Reset mid-PENDING drops the change
    do_op(0, 2);
    chk("prerst.cfg_pending", cfg_pending, 1);
    reset_n = 1'b0; #1;
    chk_all("rst", 0, 0, 80, 150, 0, 0, cfg_update);
    tick(2); reset_n = 1'b1; tick(2);
    u0 = upd_total;
    do_op(1, 0);
    chk("postrst.updates", upd_total - u0, 0);
    chk("postrst.bright_enable", bright_enable, 0);

    // Key held through reset release must be debounced afresh
    key_n[0] = 1'b0; reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(4);
    chk("heldrst.early_pending", cfg_pending, 0);
    tick(5);
    chk("heldrst.late_pending", cfg_pending, 1);
    key_n[0] = 1'b1; tick(10);

    reset_dut();
    for (int i = 0; i < 22; i++) begin
      u0 = upd_total;
      do_op(tbl[i].op, tbl[i].mask);
      chk_all($sformatf("vec%0d", i), tbl[i].te, tbl[i].be, tbl[i].tl, tbl[i].bl,
              tbl[i].pend, tbl[i].upd, upd_total - u0);
    end

    reset_dut();
    m_te = 0; m_be = 0; m_idx = 0; m_pend = 0; a_te = 0; a_be = 0; a_idx = 0;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 0;
        4, 5:       op = 1;
        6:          op = 2;
        7:          op = 4;
        default:    op = 5;
      endcase
      mask = $urandom_range(1, 7);
      u0 = upd_total;
      do_op(op, mask);
      model_op(op, mask, eu);
      chk_all($sformatf("rnd%0d", i), a_te, a_be, tp[a_idx], bp[a_idx], m_pend, eu,
              upd_total - u0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
